uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
- Sits inside `main`, directly downstream of the UART receiver that samples `rxd_i`.
- Consumes the received byte stream and packs bytes little-endian into 32-bit words.
- Writes the first IMEM_ENTRIES words into instruction memory, then the next DMEM_ENTRIES words into data memory.
- Holds the CPU in reset until the last word is written, then releases it and idles.

Parameters:
- IMEM_ENTRIES, 1024, number of 32-bit words written to instruction memory; must be ≥1.
- DMEM_ENTRIES, 1024, number of 32-bit words written to data memory; must be ≥1.
- IADDR_W, $clog2(IMEM_ENTRIES), instruction-memory word-address width.
- DADDR_W, $clog2(DMEM_ENTRIES), data-memory word-address width.

Ports:
- clk_i  in  1  system clock; all logic is on its rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- rvalid_i  in  1  received byte valid, from the UART receiver.
- rdata_i  in  8  received byte.
- rready_o  out  1  loader accepts a byte; a byte is taken in any cycle with rvalid_i & rready_o.
- imem_we_o  out  1  instruction-memory write strobe, one-cycle pulse.
- imem_addr_o  out  IADDR_W  instruction-memory word address.
- imem_wdata_o  out  32  instruction-memory write data.
- dmem_we_o  out  1  data-memory write strobe, one-cycle pulse.
- dmem_addr_o  out  DADDR_W  data-memory word address.
- dmem_wdata_o  out  32  data-memory write data.
- cpu_rst_o  out  1  active-high CPU reset; 1 while loading.
- done_o  out  1  load complete, sticky until reset.
- csum_o  out  32  running XOR of every word written, IMEM and DMEM.

Behaviour:
- Reset (rst_ni=0 sampled at a clock edge):
  - State ← LOAD_IMEM; byte offset ← 0; word counter ← 0; shift register ← 0; csum_o ← 0.
  - imem_we_o = dmem_we_o = 0; both addresses ← 0; both wdata ← 0.
  - cpu_rst_o ← 1; done_o ← 0; rready_o ← 1.
  - Reset mid-load discards the partial word and restarts at IMEM word 0. Memory contents are not cleared.
- Byte packing:
  - An accepted byte at offset k (0..3) goes to bits [8k+7:8k]; offset then increments mod 4.
  - The 1st received byte is the LSB.
- Word write:
  - When the byte at offset 3 is accepted in cycle N, the matching we_o is 1 in cycle N+1 only.
  - addr_o and wdata_o are registered and valid in that same cycle N+1; they hold their values afterwards.
  - csum_o updates in cycle N+1 as csum_o ^ word.
- State machine:
  - LOAD_IMEM: words go to imem at addr = word counter. After the write of word IMEM_ENTRIES-1 is issued: counter ← 0, state ← LOAD_DMEM. The next byte accepted, even back-to-back in cycle N+1, belongs to DMEM word 0.
  - LOAD_DMEM: same, to dmem. After word DMEM_ENTRIES-1 is issued: state ← DONE.
  - DONE: rready_o=0 and extra bytes are ignored. In the cycle after the final dmem_we_o pulse, cpu_rst_o ← 0 and done_o ← 1; both hold until reset.
- Boundaries:
  - Bytes may arrive on consecutive cycles; no bubble is needed between words.
  - Arbitrary gaps between bytes are allowed; there is no timeout.
  - The word counter width is max(IADDR_W, DADDR_W)+1, so the counter never wraps before its compare.
  - The imem and dmem strobes are never high in the same cycle.
  - If rvalid_i is high in the same cycle the state enters DONE, the byte is dropped.

Decomposition:
- Shared package `boot_pkg`:
  - state typedef {LOAD_IMEM, LOAD_DMEM, DONE};
  - byte-offset width constant (2);
  - the sim end address constant 32'h1000_0000 and pass token 32'h777, used by benches.
- One sub-module, `word_packer`:
  - byte in, 32-bit word out with a one-cycle word_valid pulse;
  - owns the offset counter and shift register;
  - the parent owns the FSM, counters, strobes and checksum.

Test Plan:
- Minimal load: IMEM_ENTRIES=2, DMEM_ENTRIES=1; send bytes 78 56 34 12, EF BE AD DE, 01 00 00 00. Expected:
  - imem[0]=32'h12345678 and imem[1]=32'hDEADBEEF;
  - dmem[0]=32'h00000001;
  - csum_o=32'hCC99E896;
  - cpu_rst_o falls exactly 1 cycle after the dmem_we_o pulse.
- Back-to-back: bytes on 12 consecutive cycles with rvalid_i=1. Expected:
  - each we pulse exactly 1 cycle after the 4th byte of its word;
  - no byte is lost at the IMEM→DMEM switch.
- Gapped stream: random 0–500 idle cycles between bytes. Expected: memory contents and csum_o identical to the minimal-load case.
- Reset mid-word: send 2 bytes, assert rst_ni=0 for 1 cycle, then send the full stream. Expected:
  - imem[0] equals the first 4 bytes sent after reset;
  - no write occurs before reset completes.
- Overflow bytes: after done_o=1, drive 8 more bytes. Expected:
  - rready_o=0;
  - no we pulses;
  - csum_o and cpu_rst_o=0 unchanged.
- Full system: IMEM_ENTRIES=DMEM_ENTRIES=1024 with a program image. Expected: the CPU stores 32'h777 to 32'h1000_0000 before the cycle limit.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
// Loader FSM states, byte-offset width and simulation end/pass markers.
package boot_pkg;

  typedef enum logic [1:0] {
    LOAD_IMEM,
    LOAD_DMEM,
    DONE
  } boot_state_e;

  localparam int OFF_W = 2;

  localparam logic [31:0] SIM_END_ADDR = 32'h1000_0000;
  localparam logic [31:0] PASS_TOKEN   = 32'h0000_0777;

endpackage

// File: rtl/word_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
// Ports: clk_i, rst_ni, byte_valid_i/byte_i in; word_valid_o/word_o out.
module word_packer
  import boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [OFF_W-1:0] off_q;
  logic [23:0]      sh_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      off_q <= '0;
      sh_q  <= '0;
    end else if (byte_valid_i) begin
      off_q <= off_q + 1'b1;
      case (off_q)
        2'd0:    sh_q[7:0]   <= byte_i;
        2'd1:    sh_q[15:8]  <= byte_i;
        2'd2:    sh_q[23:16] <= byte_i;
        default: sh_q        <= sh_q;
      endcase
    end
  end

  // The 4th byte completes the word combinationally; the parent
  // registers it so the write appears in the following cycle.
  assign word_valid_o = byte_valid_i & (off_q == 2'd3);
  assign word_o       = {byte_i, sh_q};

endmodule

// File: rtl/uart_boot_loader.sv
// Loads IMEM then DMEM from a UART byte stream, holding the CPU in reset.
// Ports: rvalid_i/rdata_i/rready_o byte in; imem_*/dmem_* writes; cpu_rst_o, done_o, csum_o.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_ENTRIES = 1024,
  parameter int DMEM_ENTRIES = 1024,
  parameter int IADDR_W = (IMEM_ENTRIES > 1) ? $clog2(IMEM_ENTRIES) : 1,
  parameter int DADDR_W = (DMEM_ENTRIES > 1) ? $clog2(DMEM_ENTRIES) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               rvalid_i,
  input  logic [7:0]         rdata_i,
  output logic               rready_o,
  output logic               imem_we_o,
  output logic [IADDR_W-1:0] imem_addr_o,
  output logic [31:0]        imem_wdata_o,
  output logic               dmem_we_o,
  output logic [DADDR_W-1:0] dmem_addr_o,
  output logic [31:0]        dmem_wdata_o,
  output logic               cpu_rst_o,
  output logic               done_o,
  output logic [31:0]        csum_o
);

  // One extra bit so the last index compares before any wrap.
  localparam int CNT_W =
    ((IADDR_W > DADDR_W) ? IADDR_W : DADDR_W) + 1;
  localparam logic [CNT_W-1:0] I_LAST = CNT_W'(IMEM_ENTRIES - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DMEM_ENTRIES - 1);

  boot_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             iwe_d, dwe_d;
  logic             iwe_q, dwe_q;
  logic [IADDR_W-1:0] iaddr_q;
  logic [DADDR_W-1:0] daddr_q;
  logic [31:0]      iwdata_q, dwdata_q;
  logic [31:0]      csum_q;
  logic             done_q;

  logic             accept;
  logic             word_valid;
  logic [31:0]      word;

  assign rready_o = (state_q != DONE);
  assign accept   = rvalid_i & rready_o;

  word_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .byte_valid_i (accept),
    .byte_i       (rdata_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iwe_d   = 1'b0;
    dwe_d   = 1'b0;
    case (state_q)
      LOAD_IMEM: begin
        if (word_valid) begin
          iwe_d = 1'b1;
          if (cnt_q == I_LAST) begin
            cnt_d   = '0;
            state_d = LOAD_DMEM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_DMEM: begin
        if (word_valid) begin
          dwe_d = 1'b1;
          if (cnt_q == D_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= LOAD_IMEM;
      cnt_q    <= '0;
      iwe_q    <= 1'b0;
      dwe_q    <= 1'b0;
      iaddr_q  <= '0;
      daddr_q  <= '0;
      iwdata_q <= '0;
      dwdata_q <= '0;
      csum_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iwe_q   <= iwe_d;
      dwe_q   <= dwe_d;
      if (iwe_d) begin
        iaddr_q  <= cnt_q[IADDR_W-1:0];
        iwdata_q <= word;
      end
      if (dwe_d) begin
        daddr_q  <= cnt_q[DADDR_W-1:0];
        dwdata_q <= word;
      end
      if (word_valid) csum_q <= csum_q ^ word;
      // Final DMEM pulse is the only one seen while already in DONE.
      done_q <= done_q | (dwe_q & (state_q == DONE));
    end
  end

  assign imem_we_o    = iwe_q;
  assign imem_addr_o  = iaddr_q;
  assign imem_wdata_o = iwdata_q;
  assign dmem_we_o    = dwe_q;
  assign dmem_addr_o  = daddr_q;
  assign dmem_wdata_o = dwdata_q;
  assign csum_o       = csum_q;
  assign done_o       = done_q;
  assign cpu_rst_o    = ~done_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed/randomized bench for uart_boot_loader (2 IMEM words, 1 DMEM word).
// Checks memory image, checksum, strobe timing, reset and overflow behaviour.
module tb_uart_boot_loader;

  localparam int NI = 2;
  localparam int ND = 1;
  localparam int NB = 4 * (NI + ND);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rvalid = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        rready;
  logic        imem_we;
  logic [0:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [0:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        cpu_rst;
  logic        done;
  logic [31:0] csum;

  int checks = 0;
  int failures = 0;

  uart_boot_loader #(
    .IMEM_ENTRIES (NI),
    .DMEM_ENTRIES (ND)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rvalid_i     (rvalid),
    .rdata_i      (rdata),
    .rready_o     (rready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .cpu_rst_o    (cpu_rst),
    .done_o       (done),
    .csum_o       (csum)
  );

  always #5 clk = ~clk;

  // Monitor: samples pre-edge values at every rising edge.
  int          cyc = 0;
  int          acc_n = 0;
  int          b4_q[$];
  int          we_q[$];
  logic [31:0] cap_i [0:1];
  logic [31:0] cap_d [0:1];
  int          imem_n = 0;
  int          dmem_n = 0;
  int          dwe_cyc = -1;
  int          done_cyc = -1;
  bit          both = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      acc_n = 0;
      b4_q.delete();
      we_q.delete();
      cap_i[0] = '0; cap_i[1] = '0;
      cap_d[0] = '0; cap_d[1] = '0;
      imem_n = 0;
      dmem_n = 0;
      dwe_cyc = -1;
      done_cyc = -1;
      both = 1'b0;
    end else begin
      if (rvalid && rready) begin
        if (acc_n % 4 == 3) b4_q.push_back(cyc);
        acc_n++;
      end
      if (imem_we) begin
        cap_i[imem_addr] = imem_wdata;
        imem_n++;
        we_q.push_back(cyc);
      end
      if (dmem_we) begin
        cap_d[dmem_addr] = dmem_wdata;
        dmem_n++;
        we_q.push_back(cyc);
        dwe_cyc = cyc;
      end
      if (imem_we && dmem_we) both = 1'b1;
      if (done && done_cyc < 0) done_cyc = cyc;
    end
    cyc++;
  end

  logic [7:0] stim [NB];

  function automatic logic [31:0] model_word(input int w);
    int v;
    v = 0;
    for (int k = 0; k < 4; k++)
      v += int'(stim[4*w+k]) * (1 << (8*k));
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_csum();
    logic [31:0] x;
    x = '0;
    for (int w = 0; w < NI + ND; w++) x ^= model_word(w);
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input int first, input int last,
                      input int gmin, input int gmax);
    for (int i = first; i <= last; i++) begin
      repeat ($urandom_range(gmax, gmin)) begin
        @(negedge clk);
        rvalid = 1'b0;
      end
      @(negedge clk);
      rvalid = 1'b1;
      rdata = stim[i];
    end
    @(negedge clk);
    rvalid = 1'b0;
  endtask

  task automatic verify(input string tag);
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    repeat (2) @(negedge clk);
    chk({tag, "_imem0"}, cap_i[0], model_word(0));
    chk({tag, "_imem1"}, cap_i[1], model_word(1));
    chk({tag, "_dmem0"}, cap_d[0], model_word(2));
    chk({tag, "_csum"}, csum, model_csum());
    chk({tag, "_imem_n"}, 32'(imem_n), 32'(NI));
    chk({tag, "_dmem_n"}, 32'(dmem_n), 32'(ND));
    chk({tag, "_we_cnt"}, 32'(we_q.size()), 32'(b4_q.size()));
    for (int i = 0; i < we_q.size() && i < b4_q.size(); i++)
      chk({tag, "_we_lat"}, 32'(we_q[i]), 32'(b4_q[i] + 1));
    chk({tag, "_done_lat"}, 32'(done_cyc), 32'(dwe_cyc + 1));
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    chk({tag, "_no_overlap"}, 32'(both), 32'd0);
  endtask

  initial begin
    logic [31:0] csum_hold;
    int          in_n, dn_n;
    logic [7:0]  fixed [NB];

    fixed = '{8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE,
              8'h01, 8'h00, 8'h00, 8'h00};

    // Reset state
    do_reset();
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rready", 32'(rready), 32'd1);
    chk("rst_csum", csum, 32'h0);
    chk("rst_we", {30'd0, imem_we, dmem_we}, 32'd0);
    chk("rst_addr", {30'd0, imem_addr, dmem_addr}, 32'd0);
    chk("rst_wdata", imem_wdata | dmem_wdata, 32'h0);

    // Minimal load with one idle cycle between bytes
    stim = fixed;
    send(0, NB - 1, 1, 1);
    verify("min");
    chk("min_imem0_abs", cap_i[0], 32'h1234_5678);
    chk("min_imem1_abs", cap_i[1], 32'hDEAD_BEEF);
    chk("min_dmem0_abs", cap_d[0], 32'h0000_0001);
    chk("min_csum_abs", csum, 32'hCC99_E896);

    // Back-to-back bytes
    do_reset();
    send(0, NB - 1, 0, 0);
    verify("b2b");

    // Long random gaps, same image
    do_reset();
    send(0, NB - 1, 0, 500);
    verify("gap");
    chk("gap_csum_abs", csum, 32'hCC99_E896);

    // Random images with short random gaps
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NB; i++) stim[i] = 8'($urandom_range(255, 0));
      do_reset();
      send(0, NB - 1, 0, 3);
      verify("rand");
    end

    // Reset mid-word
    do_reset();
    for (int i = 0; i < NB; i++) stim[i] = 8'($urandom_range(255, 0));
    send(0, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("midrst_no_write", 32'(imem_n + dmem_n), 32'd0);
    do_reset();
    for (int i = 0; i < NB; i++) stim[i] = 8'($urandom_range(255, 0));
    send(0, NB - 1, 0, 2);
    verify("midrst");

    // Overflow bytes after load complete
    csum_hold = csum;
    in_n = imem_n;
    dn_n = dmem_n;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rvalid = 1'b1;
      rdata = 8'($urandom_range(255, 0));
      chk("ovf_rready", 32'(rready), 32'd0);
    end
    @(negedge clk);
    rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf_we_cnt", 32'(imem_n + dmem_n), 32'(in_n + dn_n));
    chk("ovf_csum", csum, csum_hold);
    chk("ovf_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("ovf_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
